recv_match: RTL and testbench
=============================

RECV_MATCH -- requirements
Module: recv_match

Interface
REQ-001 SHALL have parameter BAUD, default 104, meaning clk cycles per UART bit (115200 baud at 12 MHz); legal minimum 4.
REQ-002 SHALL have port clk  input  1  system clock, all logic on the rising edge.
REQ-003 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port rx  input  1  asynchronous UART serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port data  output  8  last correctly framed received byte.
REQ-006 SHALL have port rcv  output  1  one-cycle pulse when data is updated.
REQ-007 SHALL have port ferr  output  1  one-cycle pulse on a stop-bit error.
REQ-008 SHALL have port match  output  1  one-cycle pulse when the full sequence "Hola!..." completes.
REQ-009 SHALL have port led  output  8  mirrors data.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer preset to 1; all decoding uses the synchronized value rxs.
REQ-011 SHALL implement receiver FSM states IDLE, START, DATA, STOP, with a bit-timer counter and a 3-bit bit index.
REQ-012 IDLE: when rxs==0, SHALL load the timer and go to START.
REQ-013 START: after BAUD/2 cycles, SHALL sample rxs; if 0, go to DATA; if 1, treat as a glitch and return to IDLE with no pulse.
REQ-014 DATA: every BAUD cycles, SHALL sample rxs into the shift register, LSB first; after the 8th sample, go to STOP.
REQ-015 STOP: after BAUD cycles, SHALL sample rxs; if 1, load data from the shift register and pulse rcv; if 0, pulse ferr and leave data unchanged; then return to IDLE in both cases.
REQ-016 rcv/ferr SHALL assert BAUD/2 + 9*BAUD + 1 cycles (±1) after the first cycle rxs==0, and SHALL never assert together.
REQ-017 Back-to-back frames with a single stop bit SHALL be received without loss, since IDLE re-arms on the cycle after STOP.
REQ-018 The matcher SHALL hold index idx (0..7) into the constant sequence "H","o","l","a","!",".",".","." (0x48 0x6F 0x6C 0x61 0x21 0x2E 0x2E 0x2E).
REQ-019 On rcv with byte == seq[idx]: if idx==7, SHALL pulse match in the same cycle data becomes visible +1 and set idx to 0; otherwise increment idx.
REQ-020 On rcv with a mismatching byte: SHALL set idx to 1 if the byte is "H", else set idx to 0.
REQ-021 On ferr, SHALL set idx to 0.
REQ-022 match SHALL assert at most once per completed sequence; an overlapping new "H" after the final "." SHALL start a new sequence.

Reset
REQ-023 On rstn==0 at a clock edge: FSM=IDLE, timer=0, bit index=0, shift=0, data=0x00, led=0x00, rcv=0, ferr=0, match=0, idx=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no rcv/ferr pulse; after release, the receiver SHALL wait for rxs==0 in IDLE.

Structure
REQ-025 The shared package/header SHALL hold the BAUD divisor constants (B115200 etc.), the FSM state encodings, and the 8-byte expected sequence constant.
REQ-026 The bit-level receiver SHALL be the sub-module uart_rx (clk, rstn, rx -> data, rcv, ferr), instantiated once; recv_match SHALL add the matcher and led logic.

Verification
REQ-027 BAUD=4: send "Hola!..." as 8 frames -> 8 rcv pulses, exactly one match pulse after the 8th, led=0x2E, no ferr.
REQ-028 BAUD=4: rx low for 1 cycle then high -> no rcv, no ferr, FSM back in IDLE.
REQ-029 BAUD=4: frame 0x41 with stop bit 0 -> one ferr pulse, data keeps its previous value, idx=0.
REQ-030 BAUD=4: send "HHola!..." -> one match pulse; send "Hola!.X." -> no match, idx=0 after "X".
REQ-031 BAUD=4: assert rstn low during bit 3 of a frame, release, send 0xA5 -> exactly one rcv with data=0xA5.
REQ-032 BAUD=104: send 0x55 then 0xAA with no idle gap -> two rcv pulses, spaced 10*BAUD ±1 cycles, with correct data.

Source files
------------

// File: rtl/recv_match_pkg.sv
// Shared constants for the UART "Hola!..." receiver/matcher.
// Holds baud divisors for a 12 MHz clock, receiver FSM encodings and the
// expected 8-byte sequence with a helper to pick one byte out of it.
package recv_match_pkg;

    // clk cycles per UART bit at 12 MHz
    localparam int B9600   = 1250;
    localparam int B19200  = 625;
    localparam int B57600  = 208;
    localparam int B115200 = 104;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam int SEQ_LEN = 8;

    // "Hola!..." packed with byte i at bits [8*i +: 8]
    localparam logic [63:0] SEQ = {8'h2E, 8'h2E, 8'h2E, 8'h21,
                                   8'h61, 8'h6C, 8'h6F, 8'h48};
    localparam logic [7:0]  SEQ_FIRST = 8'h48;

    function automatic logic [7:0] seq_byte(input logic [2:0] i);
        return SEQ[{i, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/recv_match_uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling.
// Ports: clk, rstn (sync, active-low), rx (async line) -> data (last good byte),
//        rcv (1-cycle pulse on good frame), ferr (1-cycle pulse on bad stop bit).
module uart_rx
    import recv_match_pkg::*;
#(
    parameter int BAUD = B115200    // clk cycles per bit, minimum 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr
);

    localparam int TW = (BAUD > 1) ? $clog2(BAUD) : 1;
    localparam logic [TW-1:0] T_FULL = TW'(BAUD - 1);
    localparam logic [TW-1:0] T_HALF = TW'(BAUD / 2 - 1);

    logic            rx_meta;
    logic            rxs;
    rx_state_t       state,   state_nxt;
    logic [TW-1:0]   timer,   timer_nxt;
    logic [2:0]      bit_idx, bit_nxt;
    logic [7:0]      shift,   shift_nxt;
    logic [7:0]      data_nxt;
    logic            rcv_nxt;
    logic            ferr_nxt;

    // Two-flop synchronizer; preset high so reset looks like an idle line.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            data    <= 8'h00;
            rcv     <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_idx <= bit_nxt;
            shift   <= shift_nxt;
            data    <= data_nxt;
            rcv     <= rcv_nxt;
            ferr    <= ferr_nxt;
        end
    end

    // The timer counts down to zero; the sample is taken on the zero cycle,
    // giving BAUD/2 cycles to mid-start-bit and BAUD cycles between samples.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        data_nxt  = data;
        rcv_nxt   = 1'b0;
        ferr_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    timer_nxt = T_HALF;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (timer != '0) begin
                    timer_nxt = timer - TW'(1);
                end else if (!rxs) begin
                    timer_nxt = T_FULL;
                    bit_nxt   = 3'd0;
                    state_nxt = ST_DATA;
                end else begin
                    // line went back high before mid-bit: a glitch, not a frame
                    state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (timer != '0) begin
                    timer_nxt = timer - TW'(1);
                end else begin
                    shift_nxt = {rxs, shift[7:1]};
                    timer_nxt = T_FULL;
                    if (bit_idx == 3'd7) begin
                        bit_nxt   = 3'd0;
                        state_nxt = ST_STOP;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (timer != '0) begin
                    timer_nxt = timer - TW'(1);
                end else begin
                    if (rxs) begin
                        data_nxt = shift;
                        rcv_nxt  = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                    // back to IDLE straight from mid-stop-bit so a following
                    // start bit is never missed
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/recv_match.sv
// recv_match: UART receiver plus detector for the byte sequence "Hola!...".
// Ports: clk, rstn (sync, active-low), rx -> data/led (last good byte),
//        rcv, ferr (from receiver), match (1-cycle pulse, one cycle after final rcv).
module recv_match
    import recv_match_pkg::*;
#(
    parameter int BAUD = B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr,
    output logic       match,
    output logic [7:0] led
);

    logic [2:0] idx;    // position of the next expected byte in SEQ

    uart_rx #(
        .BAUD (BAUD)
    ) u_rx (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .data (data),
        .rcv  (rcv),
        .ferr (ferr)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx   <= 3'd0;
            match <= 1'b0;
        end else begin
            match <= 1'b0;
            if (ferr) begin
                idx <= 3'd0;
            end else if (rcv) begin
                if (data == seq_byte(idx)) begin
                    if (idx == 3'd7) begin
                        match <= 1'b1;
                        idx   <= 3'd0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end else begin
                    // a stray 'H' may itself be the start of a fresh sequence
                    idx <= (data == SEQ_FIRST) ? 3'd1 : 3'd0;
                end
            end
        end
    end

    assign led = data;

endmodule

// File: tb/tb_recv_match.sv
module tb_recv_match;
    import recv_match_pkg::*;

    localparam int BAUD_S = 4;
    localparam int BAUD_L = B115200;
    // cycles from driving the start bit to seeing rcv/ferr: 2 sync + BAUD/2 + 9*BAUD + 1
    localparam int LAT_S  = 2 + BAUD_S / 2 + 9 * BAUD_S + 1;
    localparam int LAT_L  = 2 + BAUD_L / 2 + 9 * BAUD_L + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn_s, rx_s, rcv_s, ferr_s, match_s;
    logic [7:0] data_s, led_s;
    logic       rstn_l, rx_l, rcv_l, ferr_l, match_l;
    logic [7:0] data_l, led_l;

    recv_match #(.BAUD(BAUD_S)) dut_s (
        .clk(clk), .rstn(rstn_s), .rx(rx_s), .data(data_s),
        .rcv(rcv_s), .ferr(ferr_s), .match(match_s), .led(led_s)
    );

    recv_match #(.BAUD(BAUD_L)) dut_l (
        .clk(clk), .rstn(rstn_l), .rx(rx_l), .data(data_l),
        .rcv(rcv_l), .ferr(ferr_l), .match(match_l), .led(led_l)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // scoreboard for the small-BAUD instance
    logic [7:0] exp_q[$];
    int         st_q[$];
    int         rcv_cnt = 0, ferr_cnt = 0, match_cnt = 0, last_rcv_cyc = -10;
    int         mon_st;
    logic [7:0] mon_e;

    // observations for the large-BAUD instance
    int         l_rcv_cnt = 0, l_ferr_cnt = 0, l_match_cnt = 0;
    logic [7:0] l_data[$];
    int         l_cyc[$];

    logic [7:0] hola [8] = '{8'h48, 8'h6F, 8'h6C, 8'h61, 8'h21, 8'h2E, 8'h2E, 8'h2E};

    always @(negedge clk) begin
        if (rcv_s || ferr_s) begin
            checks++;
            if (rcv_s && ferr_s) begin
                errors++;
                $display("FAIL rcv_ferr_exclusive rcv=%b ferr=%b required not both", rcv_s, ferr_s);
            end
            checks++;
            if (st_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame_end at cycle %0d, no frame outstanding", cyc);
            end else begin
                mon_st = st_q.pop_front();
                if ((cyc - mon_st) < LAT_S - 1 || (cyc - mon_st) > LAT_S + 1) begin
                    errors++;
                    $display("FAIL frame_latency got %0d required %0d+-1", cyc - mon_st, LAT_S);
                end
            end
        end
        if (rcv_s) begin
            rcv_cnt++;
            last_rcv_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rcv data=%h, none expected", data_s);
            end else begin
                mon_e = exp_q.pop_front();
                if (data_s !== mon_e || led_s !== mon_e) begin
                    errors++;
                    $display("FAIL rcv_data data=%h led=%h required %h", data_s, led_s, mon_e);
                end
            end
        end
        if (ferr_s) ferr_cnt++;
        if (match_s) begin
            match_cnt++;
            checks++;
            if (cyc != last_rcv_cyc + 1) begin
                errors++;
                $display("FAIL match_timing match at %0d required %0d", cyc, last_rcv_cyc + 1);
            end
        end
        if (rcv_l) begin
            l_rcv_cnt++;
            l_data.push_back(data_l);
            l_cyc.push_back(cyc);
        end
        if (ferr_l)  l_ferr_cnt++;
        if (match_l) l_match_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit big, input logic v);
        if (big) rx_l = v;
        else     rx_s = v;
    endtask

    task automatic send_frame(input bit big, input logic [7:0] b, input bit good);
        int bd;
        bd = big ? BAUD_L : BAUD_S;
        if (!big) begin
            st_q.push_back(cyc);
            if (good) exp_q.push_back(b);
        end
        drive(big, 1'b0);
        step(bd);
        for (int i = 0; i < 8; i++) begin
            drive(big, b[i]);
            step(bd);
        end
        if (good) begin
            drive(big, 1'b1);
            step(bd);
        end else begin
            // low only through the mid-stop sample so the line is idle again at once
            drive(big, 1'b0);
            step(bd / 2 + 1);
            drive(big, 1'b1);
            step(bd - bd / 2 - 1);
        end
    endtask

    task automatic test_reset;
        rx_s = 1'b1; rx_l = 1'b1;
        rstn_s = 1'b0; rstn_l = 1'b0;
        step(3);
        checks++;
        if (data_s !== 8'h00 || led_s !== 8'h00) begin
            errors++;
            $display("FAIL reset_data data=%h led=%h required 00", data_s, led_s);
        end
        checks++;
        if (rcv_s !== 1'b0 || ferr_s !== 1'b0 || match_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses rcv=%b ferr=%b match=%b required 0", rcv_s, ferr_s, match_s);
        end
        checks++;
        if (dut_s.idx !== 3'd0 || dut_s.u_rx.state !== ST_IDLE || dut_s.u_rx.rxs !== 1'b1) begin
            errors++;
            $display("FAIL reset_state idx=%0d state=%0d rxs=%b required 0/IDLE/1",
                     dut_s.idx, dut_s.u_rx.state, dut_s.u_rx.rxs);
        end
        checks++;
        if (data_l !== 8'h00 || rcv_l !== 1'b0) begin
            errors++;
            $display("FAIL reset_large data=%h rcv=%b required 00/0", data_l, rcv_l);
        end
        rstn_s = 1'b1; rstn_l = 1'b1;
        step(4);
    endtask

    task automatic test_sequence;
        int r0, f0, m0;
        r0 = rcv_cnt; f0 = ferr_cnt; m0 = match_cnt;
        for (int i = 0; i < 8; i++) send_frame(1'b0, hola[i], 1'b1);
        step(8);
        checks++;
        if (rcv_cnt - r0 != 8 || ferr_cnt - f0 != 0) begin
            errors++;
            $display("FAIL seq_counts rcv=%0d ferr=%0d required 8/0", rcv_cnt - r0, ferr_cnt - f0);
        end
        checks++;
        if (match_cnt - m0 != 1) begin
            errors++;
            $display("FAIL seq_match got %0d required 1", match_cnt - m0);
        end
        checks++;
        if (led_s !== 8'h2E || dut_s.idx !== 3'd0) begin
            errors++;
            $display("FAIL seq_final led=%h idx=%0d required 2E/0", led_s, dut_s.idx);
        end
    endtask

    task automatic test_glitch;
        int r0, f0;
        r0 = rcv_cnt; f0 = ferr_cnt;
        rx_s = 1'b0;
        step(1);
        rx_s = 1'b1;
        step(3 * BAUD_S);
        checks++;
        if (rcv_cnt != r0 || ferr_cnt != f0) begin
            errors++;
            $display("FAIL glitch_pulses rcv=%0d ferr=%0d required 0/0", rcv_cnt - r0, ferr_cnt - f0);
        end
        checks++;
        if (dut_s.u_rx.state !== ST_IDLE) begin
            errors++;
            $display("FAIL glitch_state got %0d required IDLE", dut_s.u_rx.state);
        end
    endtask

    task automatic test_frame_error;
        int f0;
        send_frame(1'b0, 8'h48, 1'b1);
        step(4);
        checks++;
        if (dut_s.idx !== 3'd1) begin
            errors++;
            $display("FAIL ferr_pre_idx got %0d required 1", dut_s.idx);
        end
        f0 = ferr_cnt;
        send_frame(1'b0, 8'h41, 1'b0);
        step(6);
        checks++;
        if (ferr_cnt - f0 != 1) begin
            errors++;
            $display("FAIL ferr_count got %0d required 1", ferr_cnt - f0);
        end
        checks++;
        if (data_s !== 8'h48 || dut_s.idx !== 3'd0) begin
            errors++;
            $display("FAIL ferr_hold data=%h idx=%0d required 48/0", data_s, dut_s.idx);
        end
    endtask

    task automatic test_overlap;
        int m0;
        logic [7:0] bad [8];
        m0 = match_cnt;
        send_frame(1'b0, 8'h48, 1'b1);
        send_frame(1'b0, 8'h48, 1'b1);
        step(4);
        checks++;
        if (dut_s.idx !== 3'd1) begin
            errors++;
            $display("FAIL hh_idx got %0d required 1", dut_s.idx);
        end
        for (int i = 1; i < 8; i++) send_frame(1'b0, hola[i], 1'b1);
        step(8);
        checks++;
        if (match_cnt - m0 != 1) begin
            errors++;
            $display("FAIL hhola_match got %0d required 1", match_cnt - m0);
        end
        bad = '{8'h48, 8'h6F, 8'h6C, 8'h61, 8'h21, 8'h2E, 8'h58, 8'h2E};
        m0 = match_cnt;
        for (int i = 0; i < 7; i++) send_frame(1'b0, bad[i], 1'b1);
        step(4);
        checks++;
        if (dut_s.idx !== 3'd0) begin
            errors++;
            $display("FAIL x_idx got %0d required 0", dut_s.idx);
        end
        send_frame(1'b0, bad[7], 1'b1);
        step(8);
        checks++;
        if (match_cnt != m0) begin
            errors++;
            $display("FAIL x_no_match got %0d required 0", match_cnt - m0);
        end
    endtask

    task automatic test_reset_midframe;
        int r0, f0;
        logic [7:0] partial;
        partial = 8'hC3;
        // start bit and bits 0..2, then into bit 3 -- not registered with the scoreboard
        rx_s = 1'b0;
        step(BAUD_S);
        for (int i = 0; i < 3; i++) begin
            rx_s = partial[i];
            step(BAUD_S);
        end
        rx_s = partial[3];
        step(2);
        r0 = rcv_cnt; f0 = ferr_cnt;
        rstn_s = 1'b0;
        rx_s = 1'b1;
        step(3);
        rstn_s = 1'b1;
        step(12 * BAUD_S);
        checks++;
        if (rcv_cnt != r0 || ferr_cnt != f0 || dut_s.u_rx.state !== ST_IDLE) begin
            errors++;
            $display("FAIL midreset_abort rcv=%0d ferr=%0d state=%0d required 0/0/IDLE",
                     rcv_cnt - r0, ferr_cnt - f0, dut_s.u_rx.state);
        end
        send_frame(1'b0, 8'hA5, 1'b1);
        step(8);
        checks++;
        if (rcv_cnt - r0 != 1 || data_s !== 8'hA5) begin
            errors++;
            $display("FAIL midreset_recv rcv=%0d data=%h required 1/A5", rcv_cnt - r0, data_s);
        end
    endtask

    task automatic test_back_to_back;
        int st;
        st = cyc;
        send_frame(1'b1, 8'h55, 1'b1);
        send_frame(1'b1, 8'hAA, 1'b1);
        step(30);
        checks++;
        if (l_rcv_cnt != 2 || l_ferr_cnt != 0 || l_match_cnt != 0) begin
            errors++;
            $display("FAIL b2b_counts rcv=%0d ferr=%0d match=%0d required 2/0/0",
                     l_rcv_cnt, l_ferr_cnt, l_match_cnt);
        end
        if (l_data.size() >= 2 && l_cyc.size() >= 2) begin
            checks++;
            if (l_data[0] !== 8'h55 || l_data[1] !== 8'hAA || led_l !== 8'hAA) begin
                errors++;
                $display("FAIL b2b_data got %h %h led=%h required 55 AA AA", l_data[0], l_data[1], led_l);
            end
            checks++;
            if (l_cyc[1] - l_cyc[0] < 10 * BAUD_L - 1 || l_cyc[1] - l_cyc[0] > 10 * BAUD_L + 1) begin
                errors++;
                $display("FAIL b2b_spacing got %0d required %0d+-1", l_cyc[1] - l_cyc[0], 10 * BAUD_L);
            end
            checks++;
            if (l_cyc[0] - st < LAT_L - 1 || l_cyc[0] - st > LAT_L + 1) begin
                errors++;
                $display("FAIL b2b_latency got %0d required %0d+-1", l_cyc[0] - st, LAT_L);
            end
        end
    endtask

    initial begin
        rstn_s = 1'b0; rstn_l = 1'b0;
        rx_s = 1'b1; rx_l = 1'b1;
        @(posedge clk);
        #1;
        test_reset;
        test_sequence;
        test_glitch;
        test_frame_error;
        test_overlap;
        test_reset_midframe;
        test_back_to_back;
        checks++;
        if (exp_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain data_left=%0d frames_left=%0d required 0/0",
                     exp_q.size(), st_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
